// File: rtl/simon_seq_gen.sv
// Simon Says pattern source: LFSR-driven step generator with a small step RAM,
// timed one-hot LED playback and a registered read port for the game FSM.
module simon_seq_gen #(
  parameter int          MAX_LEN   = 16,
  parameter int          ON_TICKS  = 500,
  parameter int          OFF_TICKS = 250,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         LW        = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          extend,
  input  logic          replay,
  input  logic [LW-1:0] rd_idx,
  output logic [3:0]    rd_data,
  output logic [LW:0]   length,
  output logic [15:0]   led_out,
  output logic          busy,
  output logic          play_done,
  output logic          full
);

  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_PLAY_ON,
    S_PLAY_OFF,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [LW:0]   length_q, length_d;
  logic [LW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   led_q, led_d;
  logic [3:0]    rd_data_q;
  logic          wr_en;
  logic [3:0]    first_step, next_step;
  logic [3:0]    mem [MAX_LEN];

  function automatic logic [15:0] onehot(input logic [3:0] s);
    return 16'h0001 << s;
  endfunction

  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign full      = (length_q == (LW+1)'(MAX_LEN));
  assign busy      = (state_q != S_IDLE);
  assign play_done = (state_q == S_DONE);
  assign length    = length_q;
  assign led_out   = led_q;
  assign rd_data   = rd_data_q;

  // The step being appended is not in the RAM yet, so a first-ever step is
  // taken straight from the LFSR to light the LED on the same edge.
  assign first_step = (length_q == '0) ? lfsr_q[3:0] : mem[0];
  assign next_step  = mem[ptr_q + LW'(1)];

  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    ptr_d    = ptr_q;
    tick_d   = tick_q;
    led_d    = led_q;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          length_d = '0;
          state_d  = S_APPEND;
        end else if (extend && !full) begin
          state_d = S_APPEND;
        end else if ((extend && full) || (replay && length_q != '0)) begin
          ptr_d   = '0;
          tick_d  = '0;
          led_d   = onehot(mem[0]);
          state_d = S_PLAY_ON;
        end
      end
      S_APPEND: begin
        wr_en = !full;
        if (!full) length_d = length_q + (LW+1)'(1);
        ptr_d   = '0;
        tick_d  = '0;
        led_d   = onehot(first_step);
        state_d = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        if (tick_q == TW'(ON_TICKS - 1)) begin
          tick_d  = '0;
          led_d   = '0;
          state_d = S_PLAY_OFF;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_PLAY_OFF: begin
        if (tick_q == TW'(OFF_TICKS - 1)) begin
          tick_d = '0;
          if (({1'b0, ptr_q} + (LW+1)'(1)) < length_q) begin
            ptr_d   = ptr_q + LW'(1);
            led_d   = onehot(next_step);
            state_d = S_PLAY_ON;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new game may begin at any time; it abandons whatever is playing.
    if (start && state_q != S_IDLE) begin
      length_d = '0;
      led_d    = '0;
      ptr_d    = '0;
      tick_d   = '0;
      wr_en    = 1'b0;
      state_d  = S_APPEND;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      length_q  <= '0;
      ptr_q     <= '0;
      tick_q    <= '0;
      lfsr_q    <= SEED;
      led_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      ptr_q     <= ptr_d;
      tick_q    <= tick_d;
      lfsr_q    <= lfsr_d;
      led_q     <= led_d;
      rd_data_q <= ({1'b0, rd_idx} < length_q) ? mem[rd_idx] : 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[length_q[LW-1:0]] <= lfsr_q[3:0];
  end

endmodule
